fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the MIPS core. Holds the program counter, fetches one instruction word at a time from instruction memory over a req/ack handshake, and presents it to the decoder and datapath with a valid/ready handshake. Computes the next PC (sequential, PC-relative branch, or absolute jump) from the decoder's `dobranch`/`dojump` when the presented instruction is consumed.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; registered.
- `imem_addr`  out  32  fetch address; equals `pc`; bits [1:0] always 0.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle; ignored while `imem_req`=0.
- `imem_rdata`  in  32  instruction word; sampled only on ack.
- `instr`  out  32  held instruction word; goes to the decoder `instr` input.
- `pc`  out  32  address of `instr`.
- `pcplus4`  out  32  `pc`+4, modulo 2^32.
- `instr_valid`  out  1  `instr`/`pc` are valid; registered.
- `instr_ready`  in  1  downstream consumes `instr` at this edge.
- `dobranch`  in  1  from decoder; sampled only on consume.
- `dojump`  in  1  from decoder; sampled only on consume.

## Operation
- FSM states: RST, FETCH, HOLD.
- RST: entered asynchronously on `reset_n`=0.
  - `pc`=RESET_PC, `instr`=0, `imem_req`=0, `instr_valid`=0.
  - First edge with `reset_n`=1 moves to FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc` held stable.
  - Edge with `imem_ack`=1: `instr`<=`imem_rdata`, go to HOLD.
  - Otherwise stay; no timeout.
- HOLD: `instr_valid`=1, `imem_req`=0; `instr`/`pc` stable.
  - Edge with `instr_ready`=1 (consume): `pc`<=next PC, go to FETCH.
  - Otherwise stay.
- Next PC on consume, in priority order:
  - `dojump`=1: {`pcplus4`[31:28], `instr`[25:0], 2'b00}.
  - else `dobranch`=1: `pcplus4` + {{14{`instr`[15]}}, `instr`[15:0], 2'b00}, mod 2^32.
  - else `pcplus4`.
- Both `dojump` and `dobranch` set: jump wins.
- X on `dobranch`/`dojump` (decoder default case) in HOLD without consume: no effect.
- PC wrap: 32'hFFFF_FFFC+4 yields 0; branch target wraps silently.
- One outstanding request max; no prefetch, so a redirect never needs a flush.
- `imem_ack` while `imem_req`=0 (RST/HOLD): ignored, no state change.
- Reset mid-fetch: the request is dropped. Memory shares `reset_n` and abandons in-flight reads.

## Timing
- `imem_req`, `instr_valid`, `instr`, `pc` are registers; `pcplus4` is combinational from `pc`.
- Zero-wait memory (ack the same cycle req is seen) gives:
  - cycle N: FETCH, req=1, ack=1;
  - cycle N+1: HOLD, valid=1;
  - with ready=1 in N+1, cycle N+2 is FETCH at the new PC.
- Peak throughput: 1 instruction per 2 cycles. Each extra memory wait cycle or ready-low cycle adds one cycle.
- `instr_valid` and `imem_req` are never both 1.
- First `imem_req` after reset release: the cycle after the first `clk` edge with `reset_n`=1.

## Test plan
- Reset/sequential: hold reset_n=0, release; memory acks immediately with 32'h2408_0001 at addresses 0, 4, 8 -> `imem_addr` sequence 0, 4, 8; `instr_valid` high every second cycle; `pc` matches each address.
- Wait states: ack delayed 3 cycles at addr 0 -> `imem_req` stays 1 and `imem_addr` stays 0 for 4 cycles; `instr_valid` rises the cycle after ack.
- Backpressure: `instr_ready`=0 for 5 cycles in HOLD -> `instr`, `pc`, `instr_valid` stable; `imem_req`=0; a spurious `imem_ack` causes no change.
- Branch: pc=32'h0000_0010, instr=32'h1000_FFFE, dobranch=1 on consume -> next `imem_addr`=32'h0000_000C. Same instr with dobranch=0 -> 32'h0000_0014.
- Jump/priority: pc=32'hA000_0000, instr=32'h0800_0040, dojump=1 and dobranch=1 -> next `imem_addr`=32'hA000_0100.
- Async reset mid-FETCH: pull `reset_n` low between edges with req=1 -> `imem_req`, `instr_valid` go 0 immediately without waiting for a clock edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage. Owns the PC, fetches one word per
// request over imem req/ack and hands it downstream over instr_valid/instr_ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        dobranch,
    input  logic        dojump,
    output logic [1:0]  fsm_state
);

    // Handshakes: a transfer happens at a rising edge where the producer's
    // imem_req/instr_valid and the consumer's imem_ack/instr_ready are both 1.
    // The producer holds address/payload stable until then, and ack/ready
    // seen while req/valid is low are ignored.

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        req_nxt;
    logic        valid_nxt;
    logic        fetch_done;
    logic        consume;

    logic [29:0] pc_word;
    logic [29:0] pcplus4_word;
    logic [29:0] branch_word;
    logic [29:0] jump_word;
    logic [29:0] next_word;

    assign fetch_done = (state == ST_FETCH) && imem_ack;
    assign consume    = (state == ST_HOLD) && instr_ready;
    assign fsm_state  = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:   state_nxt = ST_FETCH;
            ST_FETCH: if (imem_ack)    state_nxt = ST_HOLD;
            ST_HOLD:  if (instr_ready) state_nxt = ST_FETCH;
            default:  state_nxt = ST_RST;
        endcase
    end

    // Decode from the next state so req/valid come straight out of flops.
    always_comb begin
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
        case (state_nxt)
            ST_FETCH: req_nxt   = 1'b1;
            ST_HOLD:  valid_nxt = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            imem_req    <= req_nxt;
            instr_valid <= valid_nxt;
        end
    end

    // The PC is kept as a word address, so alignment holds by construction.
    assign pc           = {pc_word, 2'b00};
    assign imem_addr    = pc;
    assign pcplus4_word = pc_word + 30'd1;
    assign pcplus4      = {pcplus4_word, 2'b00};
    assign branch_word  = pcplus4_word + {{14{instr[15]}}, instr[15:0]};
    assign jump_word    = {pcplus4_word[29:26], instr[25:0]};

    always_comb begin
        next_word = pcplus4_word;
        if (dojump) begin
            next_word = jump_word;
        end else if (dobranch) begin
            next_word = branch_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_word <= RESET_PC[31:2];
            instr   <= 32'h0000_0000;
        end else begin
            if (fetch_done) begin
                instr <= imem_rdata;
            end
            if (consume) begin
                pc_word <= next_word;
            end
        end
    end

endmodule
